// File: rtl/mips_pkg.sv
// Shared MIPS constants: opcodes, functs, halt word and hazard FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_reg_decode.sv
// Register-usage decode of one instruction: which sources it reads, its dest, load flag.
// Latency: purely combinational.
// Backpressure: none.
module hazard_reg_decode
  import mips_pkg::*;
(
  input  logic [31:0] instruction,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic [4:0]  dest,
  output logic        is_load
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_shamt;

  assign opcode       = instruction[31:26];
  assign funct        = instruction[5:0];
  assign rt           = instruction[20:16];
  assign rd           = instruction[15:11];
  // shamt and rs field values do not affect usage or destination
  assign unused_shamt = ^{instruction[25:21], instruction[10:6]};

  // classify the instruction by opcode/funct
  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    dest    = 5'd0;
    is_load = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        // shifts by immediate take their operand from rt only
        uses_rs = !(funct == FN_SLL || funct == FN_SRL || funct == FN_SRA);
        dest    = (funct == FN_JR) ? 5'd0 : rd;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        uses_rs = 1'b1;
        dest    = rt;
      end
      OP_LW: begin
        uses_rs = 1'b1;
        dest    = rt;
        is_load = 1'b1;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      default: begin
        uses_rs = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard/sequencing control: load-use stall, taken-branch flush, halt drain and done.
// Latency: outputs are Mealy (same cycle as the ID instruction); stall 1 cycle, flush 0 cycles.
// Backpressure: stalls PC and IF/ID on load-use; freezes the front end during drain/done.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            if_id_instruction,
  input  logic                   branch_taken,
  output logic                   control_mux,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_id_flush,
  output logic                   done,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  hz_state_t  state;
  hz_state_t  state_nxt;
  logic [CNT_W-1:0] drain_cnt;

  logic [4:0] ex_dest;
  logic       ex_is_load;

  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] id_dest;
  logic       id_is_load;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       halt_id;
  logic       load_use;

  hazard_reg_decode u_decode (
    .instruction (if_id_instruction),
    .uses_rs     (id_uses_rs),
    .uses_rt     (id_uses_rt),
    .dest        (id_dest),
    .is_load     (id_is_load)
  );

  assign id_rs   = if_id_instruction[25:21];
  assign id_rt   = if_id_instruction[20:16];
  assign halt_id = (if_id_instruction == HALT_WORD);

  // only a load in EX can hurt: ALU results are forwarded
  assign load_use = ex_is_load && (ex_dest != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_dest)) ||
                     (id_uses_rt && (id_rt == ex_dest)));

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // next state: a taken branch discards a halt in ID, drain ends when the count hits 1
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (!branch_taken && halt_id) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt <= CNT_W'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_DONE;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // outputs: reset, then flush > halt > load-use > normal
  always_comb begin
    control_mux = 1'b1;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    done        = 1'b0;
    if (reset) begin
      control_mux = 1'b0;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (branch_taken) begin
            // branch target loads into PC; wrong-path fetch becomes a NOP
            if_id_flush = 1'b1;
            control_mux = 1'b0;
          end else if (halt_id || load_use) begin
            // halt freezes the front end from the detect cycle onwards
            control_mux = 1'b0;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
          end
        end
        ST_DRAIN: begin
          control_mux = 1'b0;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
        end
        ST_DONE: begin
          control_mux = 1'b0;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          done        = 1'b1;
        end
        default: begin
          control_mux = 1'b0;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
        end
      endcase
    end
  end

  // drain counter: loaded on halt detect, counts down while draining
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drain_cnt <= '0;
    end else if (state == ST_RUN && state_nxt == ST_DRAIN) begin
      drain_cnt <= CNT_W'(DRAIN_CYCLES);
    end else if (state == ST_DRAIN && drain_cnt != '0) begin
      drain_cnt <= drain_cnt - CNT_W'(1);
    end
  end

  // shadow of the instruction entering EX; a bubble carries no dest and no load
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_dest    <= 5'd0;
      ex_is_load <= 1'b0;
    end else if (control_mux) begin
      ex_dest    <= id_dest;
      ex_is_load <= id_is_load;
    end else begin
      ex_dest    <= 5'd0;
      ex_is_load <= 1'b0;
    end
  end

  // saturating count of bubble cycles, frozen once done
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (!control_mux && state != ST_DONE && stall_count != '1) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed ID-stage vectors, expected outputs queued per cycle.
// Latency: one vector per clock, outputs sampled on the falling edge.
// Backpressure: none; the bench holds stalled instructions itself.
module tb_hazard_unit;

  logic        clock;
  logic        reset;
  logic [31:0] if_id_instruction;
  logic        branch_taken;
  logic        control_mux;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        done;
  logic [15:0] stall_count;

  typedef struct packed {
    logic [4:0]  ctl;   // {control_mux, pc_write, if_id_write, if_id_flush, done}
    logic [15:0] sc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks;
  int    failures;

  localparam logic [31:0] I_LW2     = 32'h8C22_0000; // lw  $2,0($1)
  localparam logic [31:0] I_ADD_R2  = 32'h0044_1820; // add $3,$2,$4
  localparam logic [31:0] I_LW0     = 32'h8C20_0000; // lw  $0,0($1)
  localparam logic [31:0] I_ADD_R0  = 32'h0004_1820; // add $3,$0,$4
  localparam logic [31:0] I_SLL_R2  = 32'h0002_1880; // sll $3,$2,2
  localparam logic [31:0] I_SLL_R5  = 32'h0005_1880; // sll $3,$5,2
  localparam logic [31:0] I_NOP     = 32'h0000_0000;
  localparam logic [31:0] I_HALT    = 32'hFFFF_FFFF;

  // {cm, pw, iw, fl, dn}
  localparam logic [4:0] O_RUN   = 5'b11100;
  localparam logic [4:0] O_STALL = 5'b00000;
  localparam logic [4:0] O_FLUSH = 5'b01110;
  localparam logic [4:0] O_DONE  = 5'b00001;
  localparam logic [4:0] O_RST   = 5'b00010;

  hazard_unit #(
    .DRAIN_CYCLES (3),
    .STALL_CNT_W  (16)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .if_id_instruction (if_id_instruction),
    .branch_taken      (branch_taken),
    .control_mux       (control_mux),
    .pc_write          (pc_write),
    .if_id_write       (if_id_write),
    .if_id_flush       (if_id_flush),
    .done              (done),
    .stall_count       (stall_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // drive one cycle of inputs just after the rising edge and queue what the DUT must show
  task automatic step(input string tag, input logic rst, input logic [31:0] ins,
                      input logic br, input logic [4:0] ctl, input logic [15:0] sc);
    exp_t e;
    @(posedge clock);
    #1;
    reset             = rst;
    if_id_instruction = ins;
    branch_taken      = br;
    e.ctl = ctl;
    e.sc  = sc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // monitor: compare on the falling edge whenever an expectation is pending
  initial begin
    exp_t  e;
    exp_t  act;
    string t;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        act.ctl = {control_mux, pc_write, if_id_write, if_id_flush, done};
        act.sc  = stall_count;
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got cm/pw/iw/fl/dn=%b sc=%0d, want %b sc=%0d",
                   t, act.ctl, act.sc, e.ctl, e.sc);
        end
      end
    end
  end

  initial begin
    checks            = 0;
    failures          = 0;
    reset             = 1'b1;
    if_id_instruction = 32'h0;
    branch_taken      = 1'b0;

    step("reset_state",      1'b1, I_NOP,    1'b0, O_RST,   16'd0);
    // load-use on rs
    step("lw2_issue",        1'b0, I_LW2,    1'b0, O_RUN,   16'd0);
    step("add_rs_stall",     1'b0, I_ADD_R2, 1'b0, O_STALL, 16'd0);
    step("add_after_stall",  1'b0, I_ADD_R2, 1'b0, O_RUN,   16'd1);
    // load to $0 never stalls
    step("lw0_issue",        1'b0, I_LW0,    1'b0, O_RUN,   16'd1);
    step("add_r0_nostall",   1'b0, I_ADD_R0, 1'b0, O_RUN,   16'd1);
    // shift reads rt only
    step("lw2_issue_b",      1'b0, I_LW2,    1'b0, O_RUN,   16'd1);
    step("sll_rt_stall",     1'b0, I_SLL_R2, 1'b0, O_STALL, 16'd1);
    step("sll_after_stall",  1'b0, I_SLL_R2, 1'b0, O_RUN,   16'd2);
    step("lw2_issue_c",      1'b0, I_LW2,    1'b0, O_RUN,   16'd2);
    step("sll_other_nostall",1'b0, I_SLL_R5, 1'b0, O_RUN,   16'd2);
    // flush beats load-use and halt
    step("lw2_issue_d",      1'b0, I_LW2,    1'b0, O_RUN,   16'd2);
    step("flush_over_ldu",   1'b0, I_ADD_R2, 1'b1, O_FLUSH, 16'd2);
    step("flush_over_halt",  1'b0, I_HALT,   1'b1, O_FLUSH, 16'd3);
    step("no_drain_after",   1'b0, I_NOP,    1'b0, O_RUN,   16'd4);
    // halt drain: done 3 edges after detect
    step("halt_detect",      1'b0, I_HALT,   1'b0, O_STALL, 16'd4);
    step("drain_1_br_ign",   1'b0, I_HALT,   1'b1, O_STALL, 16'd5);
    step("drain_2",          1'b0, I_HALT,   1'b0, O_STALL, 16'd6);
    step("drain_3",          1'b0, I_HALT,   1'b0, O_STALL, 16'd7);
    step("done_rise",        1'b0, I_HALT,   1'b0, O_DONE,  16'd8);
    step("done_hold",        1'b0, I_NOP,    1'b1, O_DONE,  16'd8);
    // reset in DONE, then mid-drain; reset lands between edges so only async reset shows
    step("reset_in_done",    1'b1, I_NOP,    1'b0, O_RST,   16'd0);
    step("halt_detect_2",    1'b0, I_HALT,   1'b0, O_STALL, 16'd0);
    step("drain_2_1",        1'b0, I_HALT,   1'b0, O_STALL, 16'd1);
    step("reset_mid_drain",  1'b1, I_HALT,   1'b0, O_RST,   16'd0);
    step("run_after_reset",  1'b0, I_NOP,    1'b0, O_RUN,   16'd0);
    step("run_after_reset2", 1'b0, I_NOP,    1'b0, O_RUN,   16'd0);

    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clock);
        budget--;
      end
      if (exp_q.size() > 0) begin
        checks++;
        failures++;
        $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
      end
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and sequencing controller for the five-stage MIPS core. It inspects the instruction in IF/ID, tracks shadow copies of the destination registers in flight, and drives the `control_mux` bubble input of the control decoder. It also drives the PC and IF/ID write enables and the IF/ID flush. It handles load-use stalls, taken-branch flushes and the halt-word drain, and reports completion to the testbench/top level.

## Interface
- `DRAIN_CYCLES`, 3: cycles to wait after halt detection before `done`. Default covers older instructions in EX, MEM and WB.
- `STALL_CNT_W`, 16: width of the stall performance counter.

- `clock`  in  1  core clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_id_instruction`  in  32  instruction currently in ID.
- `branch_taken`  in  1  EX-stage branch resolution. 1 = the branch in EX is taken this cycle.
- `control_mux`  out  1  0 = decoder emits a bubble (all controls zero). 1 = normal decode.
- `pc_write`  out  1  PC register load enable.
- `if_id_write`  out  1  IF/ID register load enable.
- `if_id_flush`  out  1  IF/ID loads a NOP (32'h0) at the next edge.
- `done`  out  1  program finished; stays high until reset.
- `stall_count`  out  `STALL_CNT_W`  saturating count of cycles with `control_mux`=0.

One clock; reset is asynchronous and active-high (`clock`, `reset`).

## Operation
- Field decode of the ID instruction: rs=[25:21], rt=[20:16], rd=[15:11], opcode=[31:26], funct=[5:0].
- Uses rs:
  - R-type except sll/srl/sra (funct 0/2/3).
  - addi, addiu, andi, ori, xori, lw, sw, beq, bne.
- Uses rt:
  - all R-type.
  - sw, beq, bne.
- Dest:
  - R-type: rd, except jr (funct 8), which has no dest.
  - addi/addiu/andi/ori/xori/lw: rt.
  - Dest 0 is never a hazard.
- Shadow registers, updated every edge with the instruction that enters EX:
  - `ex_dest[4:0]`, `ex_is_load`.
  - A bubble (`control_mux`=0) writes dest=0, load=0.
- ALU-result hazards are covered by the existing forwarding; only load-use stalls.
- Priority, highest first: reset, flush, halt, load-use, normal.
- FSM states:
  - RUN, normal operation. All enables 1, `control_mux`=1, `if_id_flush`=0.
    - If `branch_taken`=1: FLUSH action this cycle, then stay in RUN.
    - Else if the ID instruction is 32'hFFFFFFFF: go to DRAIN and load the counter with `DRAIN_CYCLES`.
    - Else if `ex_is_load`, `ex_dest`≠0, and `ex_dest` equals a used rs/rt: STALL action this cycle, then stay in RUN.
  - FLUSH action: `if_id_flush`=1, `control_mux`=0, `pc_write`=1 (branch target loads), `if_id_write`=1.
  - STALL action: `pc_write`=0, `if_id_write`=0, `control_mux`=0.
  - DRAIN:
    - `pc_write`=0, `if_id_write`=0, `control_mux`=0.
    - The counter decrements each cycle; go to DONE when it reaches 1.
    - `branch_taken` is ignored; only bubbles are downstream.
  - DONE: same outputs as DRAIN, plus `done`=1. Terminal state.
- `stall_count` increments on every cycle with `control_mux`=0 outside reset and DONE. It saturates at all-ones.

## Timing
- Outputs are Mealy: combinational from state, shadows and current inputs, and valid in the same cycle the instruction sits in ID.
- The state, shadows, counter and `stall_count` are registered.
- During reset (asynchronous):
  - state=RUN, shadows=0, counter=0, `stall_count`=0.
  - Outputs are forced to `pc_write`=0, `if_id_write`=0, `control_mux`=0, `if_id_flush`=1, `done`=0.
- A load-use stall lasts exactly 1 cycle. After the bubble enters EX, `ex_is_load`=0 and the held instruction proceeds.
- Flush latency is 0 cycles: the flushed instruction never reaches EX.
- `branch_taken` together with a halt in ID: the flush wins, there is no DRAIN, and the halt word is discarded.
- `branch_taken` together with a load-use condition: the flush wins.
- `done` rises exactly `DRAIN_CYCLES` cycles after the halt-detect edge.
- Reset asserted mid-DRAIN or in DONE returns to RUN immediately. `done` drops asynchronously.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (R-type, addi, addiu, andi, ori, xori, beq, bne, lw, sw).
  - funct constants (sll, srl, sra, jr).
  - `HALT_WORD`=32'hFFFFFFFF.
  - FSM state enum (RUN, DRAIN, DONE).
- Sub-module `hazard_reg_decode` (combinational): instruction → `uses_rs`, `uses_rt`, `dest[4:0]`, `is_load`. Instantiated once for the ID instruction; its dest/is_load feed the shadow registers.

## Test plan
- lw $2,0($1) then add $3,$2,$4 → one cycle with `control_mux`=0, `pc_write`=0, `if_id_write`=0; the add issues next cycle; `stall_count`=1.
- lw $0,0($1) then add $3,$0,$4 → no stall.
- lw $2 then sll $3,$2,2 (rt use) → stall. lw $2 then sll $3,$5,2 → no stall.
- `branch_taken`=1 while a halt word is in ID → `if_id_flush`=1, `pc_write`=1, no DRAIN, `done` stays 0.
- Halt word in ID with `DRAIN_CYCLES`=3 → `pc_write`=0 from that cycle; `done`=1 after exactly 3 edges and held.
- Reset pulsed mid-DRAIN → outputs take their reset values asynchronously; after release, state is RUN, `stall_count`=0 and `done`=0.
